// File: rtl/demux_sched_pkg.sv
// Shared definitions for the demux channel scheduler: channel geometry,
// FSM state encoding and the default per-channel dwell time.
package demux_sched_pkg;

    localparam int NUM_CH        = 8;
    localparam int SEL_W         = 3;
    localparam int DWELL_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/demux_sched_next_ch_find.sv
// Combinational priority search: lowest enabled channel strictly above idx,
// plus a flag telling whether any such channel exists.
module next_ch_find
    import demux_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  idx,
    output logic [SEL_W-1:0]  ch,
    output logic              found
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        ch    = '0;
        found = 1'b0;
        // Scan downwards so the lowest qualifying channel is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i > int'(idx) && mask[i]) begin
                ch    = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_sched.sv
// Frame scheduler for an external 1-to-8 demux: walks the enabled channels in
// ascending order, holding each for DWELL cycles, then pulses done.
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       data_word,
    input  logic [7:0]       ch_mask,
    output logic [SEL_W-1:0] sel,
    output logic             data_bit,
    output logic             active,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    state_t            state;
    logic [7:0]        data_q;
    logic [7:0]        mask_q;
    logic [7:0]        cnt;

    logic [NUM_CH-1:0] find_mask;
    logic [SEL_W-1:0]  find_idx;
    logic [SEL_W-1:0]  nxt_ch;
    logic              nxt_found;
    logic [SEL_W-1:0]  first_ch;

    // In IDLE the search looks at the incoming mask so the first channel is
    // known on the accepting edge; in RUN it looks above the current channel.
    always_comb begin
        find_mask = mask_q;
        find_idx  = sel;
        if (state == IDLE) begin
            find_mask = ch_mask;
            find_idx  = '0;
        end
    end

    assign first_ch = ch_mask[0] ? '0 : nxt_ch;

    next_ch_find u_find (
        .mask  (find_mask),
        .idx   (find_idx),
        .ch    (nxt_ch),
        .found (nxt_found)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the captured frame registers are reset too, so a reset leaves
            // no trace of an abandoned frame.
            state    <= IDLE;
            data_q   <= '0;
            mask_q   <= '0;
            cnt      <= '0;
            sel      <= '0;
            data_bit <= 1'b0;
            active   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        data_q <= data_word;
                        mask_q <= ch_mask;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        if (ch_mask != '0) begin
                            state    <= RUN;
                            sel      <= first_ch;
                            data_bit <= data_word[first_ch];
                            active   <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (nxt_found) begin
                            sel      <= nxt_ch;
                            data_bit <= data_q[nxt_ch];
                        end else begin
                            state    <= DONE;
                            sel      <= '0;
                            data_bit <= 1'b0;
                            active   <= 1'b0;
                            done     <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
